// File: rtl/dmem_access_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_controller_pkg
// Purpose  : Shared constants for the data-memory access controller:
//            RV32 load/store funct3 codes, controller state encodings,
//            word length and the core-request legality check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_access_controller_pkg;

  localparam int WORD_LEN = 32;

  // RV32 load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_RESP  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Returns 1 when a core request must be rejected without touching memory:
  // bad width code, unsigned store, misalignment or out-of-range address.
  function automatic logic core_req_illegal(
    input logic                wen,
    input logic [2:0]          f3,
    input logic [WORD_LEN-1:0] addr,
    input logic [WORD_LEN-1:0] mem_bytes
  );
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr[0];
      F3_W:    bad = (addr[1:0] != 2'b00);
      F3_BU:   bad = wen;
      F3_HU:   bad = wen | addr[0];
      default: bad = 1'b1;
    endcase
    if (addr >= mem_bytes) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_formatter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_formatter
// Purpose  : Combinational byte-lane logic for the data-memory controller.
//            Load path : selects the byte/half lane addressed by i_off and
//                        sign- or zero-extends it according to i_funct3.
//            Store path: replaces the addressed byte/half lane of i_word
//                        with the right-aligned store data, keeping the
//                        other lanes.
// Ports    : i_funct3    width code (F3_*)
//            i_off       byte offset within the word (addr[1:0])
//            i_word      word read from memory
//            i_wdata     right-aligned store data
//            o_load_data formatted load result
//            o_merged    word to write back for a sub-word store
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_formatter
  import dmem_access_controller_pkg::*;
(
  input  logic [2:0]          i_funct3,
  input  logic [1:0]          i_off,
  input  logic [WORD_LEN-1:0] i_word,
  input  logic [WORD_LEN-1:0] i_wdata,
  output logic [WORD_LEN-1:0] o_load_data,
  output logic [WORD_LEN-1:0] o_merged
);

  logic [WORD_LEN-1:0] w_shift;

  // Load extract / extend
  always_comb begin
    w_shift     = i_word >> {i_off, 3'b000};
    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_BU:   o_load_data = {24'h000000, w_shift[7:0]};
      F3_H:    o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_HU:   o_load_data = {16'h0000, w_shift[15:0]};
      default: o_load_data = i_word;
    endcase
  end

  // Store lane merge; halfword lanes are selected by i_off[1] only since
  // misaligned halves never reach this point.
  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_off, 3'b000} +: 8]        = i_wdata[7:0];
      F3_H:    o_merged[{i_off[1], 4'b0000} +: 16]   = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_controller
// Purpose  : Sequences all accesses to the word-only data memory (registered
//            read, 1-cycle latency). Arbitrates the core LSU against the
//            program loader (loader has priority), performs sub-word stores
//            as read-modify-write and formats loads.
// Ports    : clk, rst_n            clock / async active-low reset
//            i_core_*              core request (valid/wen/funct3/addr/wdata)
//            o_core_done/rdata/err core completion pulse and results
//            i_ld_*                loader word-write request
//            o_ld_done             loader completion pulse
//            o_mem_addr/wdata/wen  data memory command (word aligned)
//            i_mem_rdata           data memory read data
//            o_busy                controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_controller
  import dmem_access_controller_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 131072
) (
  input  logic                clk,
  input  logic                rst_n,
  // core LSU
  input  logic                i_core_valid,
  input  logic                i_core_wen,
  input  logic [2:0]          i_core_funct3,
  input  logic [WORD_LEN-1:0] i_core_addr,
  input  logic [WORD_LEN-1:0] i_core_wdata,
  output logic                o_core_done,
  output logic [WORD_LEN-1:0] o_core_rdata,
  output logic                o_core_err,
  // program loader
  input  logic                i_ld_valid,
  input  logic [WORD_LEN-1:0] i_ld_addr,
  input  logic [WORD_LEN-1:0] i_ld_wdata,
  output logic                o_ld_done,
  // data memory
  output logic [WORD_LEN-1:0] o_mem_addr,
  output logic [WORD_LEN-1:0] o_mem_wdata,
  output logic                o_mem_wen,
  input  logic [WORD_LEN-1:0] i_mem_rdata,
  // status
  output logic                o_busy
);

  localparam logic [WORD_LEN-1:0] c_mem_bytes = WORD_LEN'(MEM_BYTES);

  state_t              r_state;
  logic [2:0]          r_f3;
  logic [1:0]          r_off;
  logic [WORD_LEN-1:0] r_wdata;
  logic                r_wen;
  logic                r_src_ld;
  logic [WORD_LEN-1:0] r_mem_addr;
  logic [WORD_LEN-1:0] r_mem_wdata;
  logic                r_mem_wen;
  logic                r_core_done;
  logic [WORD_LEN-1:0] r_core_rdata;
  logic                r_core_err;
  logic                r_ld_done;
  logic                r_busy;

  logic                w_core_bad;
  logic                w_ld_bad;
  logic                w_can_accept;
  logic [WORD_LEN-1:0] w_load_data;
  logic [WORD_LEN-1:0] w_merged;

  assign w_core_bad = core_req_illegal(i_core_wen, i_core_funct3, i_core_addr, c_mem_bytes);
  assign w_ld_bad   = (i_ld_addr[1:0] != 2'b00) || (i_ld_addr >= c_mem_bytes);

  // A requester still holds its old request during its done cycle, so
  // nothing is accepted while a done pulse is being presented.
  assign w_can_accept = !(r_core_done || r_ld_done);

  dmem_lane_formatter u_fmt (
    .i_funct3    (r_f3),
    .i_off       (r_off),
    .i_word      (i_mem_rdata),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_f3         <= 3'b000;
      r_off        <= 2'b00;
      r_wdata      <= '0;
      r_wen        <= 1'b0;
      r_src_ld     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wen    <= 1'b0;
      r_core_done  <= 1'b0;
      r_core_rdata <= '0;
      r_core_err   <= 1'b0;
      r_ld_done    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Pulses and per-response results default low every cycle.
      r_core_done  <= 1'b0;
      r_core_rdata <= '0;
      r_core_err   <= 1'b0;
      r_ld_done    <= 1'b0;
      r_mem_wen    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_can_accept && i_ld_valid) begin
            r_src_ld <= 1'b1;
            r_busy   <= 1'b1;
            if (w_ld_bad) begin
              r_state <= ST_ERR;
            end else begin
              r_mem_addr  <= {i_ld_addr[WORD_LEN-1:2], 2'b00};
              r_mem_wdata <= i_ld_wdata;
              r_mem_wen   <= 1'b1;
              r_state     <= ST_WRITE;
            end
          end else if (w_can_accept && i_core_valid) begin
            r_src_ld <= 1'b0;
            r_busy   <= 1'b1;
            r_f3     <= i_core_funct3;
            r_off    <= i_core_addr[1:0];
            r_wdata  <= i_core_wdata;
            r_wen    <= i_core_wen;
            if (w_core_bad) begin
              r_state <= ST_ERR;
            end else if (i_core_wen && (i_core_funct3 == F3_W)) begin
              r_mem_addr  <= {i_core_addr[WORD_LEN-1:2], 2'b00};
              r_mem_wdata <= i_core_wdata;
              r_mem_wen   <= 1'b1;
              r_state     <= ST_WRITE;
            end else begin
              // Loads and sub-word stores both start with a word read.
              r_mem_addr <= {i_core_addr[WORD_LEN-1:2], 2'b00};
              r_state    <= ST_READ;
            end
          end
        end

        ST_READ: begin
          r_state <= r_wen ? ST_MERGE : ST_RESP;
        end

        ST_MERGE: begin
          r_mem_wdata <= w_merged;
          r_mem_wen   <= 1'b1;
          r_state     <= ST_WRITE;
        end

        ST_RESP: begin
          r_core_rdata <= w_load_data;
          r_core_done  <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end

        ST_WRITE: begin
          if (r_src_ld) begin
            r_ld_done <= 1'b1;
          end else begin
            r_core_done <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_ERR: begin
          if (r_src_ld) begin
            r_ld_done <= 1'b1;
          end else begin
            r_core_done <= 1'b1;
            r_core_err  <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_core_done  = r_core_done;
  assign o_core_rdata = r_core_rdata;
  assign o_core_err   = r_core_err;
  assign o_ld_done    = r_ld_done;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_wen    = r_mem_wen;
  assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_controller
// Purpose  : Self-checking bench for dmem_access_controller with a behavioural
//            registered-read word memory and a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_controller;
  import dmem_access_controller_pkg::*;

  localparam int MEM_BYTES = 131072;
  localparam int NWORDS    = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_valid, core_wen;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata;
  logic        core_done, core_err;
  logic [31:0] core_rdata;
  logic        ld_valid;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen;
  logic        busy;

  logic [31:0] mem [0:NWORDS-1];
  logic [7:0]  rb  [0:MEM_BYTES-1];
  int          wen_cycles = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dmem_access_controller #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_core_valid  (core_valid),
    .i_core_wen    (core_wen),
    .i_core_funct3 (core_funct3),
    .i_core_addr   (core_addr),
    .i_core_wdata  (core_wdata),
    .o_core_done   (core_done),
    .o_core_rdata  (core_rdata),
    .o_core_err    (core_err),
    .i_ld_valid    (ld_valid),
    .i_ld_addr     (ld_addr),
    .i_ld_wdata    (ld_wdata),
    .o_ld_done     (ld_done),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_wen     (mem_wen),
    .i_mem_rdata   (mem_rdata),
    .o_busy        (busy)
  );

  // Word memory: registered read every cycle, write when mem_wen.
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr[16:2]] <= mem_wdata;
      wen_cycles = wen_cycles + 1;
    end
    mem_rdata <= mem[mem_addr[16:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one core request, wait for done, hold valid through the done cycle.
  task automatic core_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
    int n;
    bit seen;
    core_valid = 1'b1; core_wen = wen; core_funct3 = f3;
    core_addr = addr; core_wdata = wdata;
    n = 0; seen = 0; rdata = 32'hx; err = 1'bx;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      if (core_done) begin
        seen = 1; rdata = core_rdata; err = core_err;
      end
    end
    lat = seen ? n - 1 : -1;
    chk("core_done_seen", {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    chk("core_done_pulse", {31'b0, core_done}, 32'd0);
    core_valid = 1'b0;
  endtask

  task automatic ld_op(input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    int n;
    bit seen;
    ld_valid = 1'b1; ld_addr = addr; ld_wdata = wdata;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      if (ld_done) seen = 1;
    end
    lat = seen ? n - 1 : -1;
    chk("ld_done_seen", {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  function automatic bit exp_err(input bit wen, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    ok = (f3 == 3'd0) || (f3 == 3'd1 && !a[0]) || (f3 == 3'd2 && a[1:0] == 2'b00) ||
         (!wen && f3 == 3'd4) || (!wen && f3 == 3'd5 && !a[0]);
    return !ok || (a >= MEM_BYTES);
  endfunction

  initial begin
    logic [31:0] rd, a, wd, exp_rd;
    logic        er;
    logic [2:0]  f3;
    logic [7:0]  b0, b1, b2, b3;
    bit          w, xe;
    int          lat, wen_snap, n, ld_n, core_n, exp_lat;

    for (int i = 0; i < NWORDS; i++) mem[i] = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) rb[i] = 8'h0;
    rst_n = 1'b0; core_valid = 0; core_wen = 0; core_funct3 = 0;
    core_addr = 0; core_wdata = 0; ld_valid = 0; ld_addr = 0; ld_wdata = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_flags", {26'b0, mem_wen, core_done, core_err, ld_done, busy, 1'b0}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: word store then load
    core_op(1, F3_W, 32'h100, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd1);
    chk("sw_err", {31'b0, er}, 32'd0);
    core_op(0, F3_W, 32'h100, 32'h0, rd, er, lat);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'b0, er}, 32'd0);

    // 2: sub-word RMW and extending loads
    core_op(1, F3_B, 32'h101, 32'h000000AA, rd, er, lat);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_mem", mem[32'h40], 32'hDEADAAEF);
    core_op(0, F3_B, 32'h101, 32'h0, rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFFFFAA);
    core_op(0, F3_BU, 32'h101, 32'h0, rd, er, lat);
    chk("lbu_rdata", rd, 32'h000000AA);
    core_op(0, F3_HU, 32'h102, 32'h0, rd, er, lat);
    chk("lhu_rdata", rd, 32'h0000DEAD);
    core_op(0, F3_H, 32'h102, 32'h0, rd, er, lat);
    chk("lh_rdata", rd, 32'hFFFFDEAD);
    core_op(1, F3_H, 32'h102, 32'hFFFF1234, rd, er, lat);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_mem", mem[32'h40], 32'h1234AAEF);
    core_op(0, F3_B, 32'h103, 32'h0, rd, er, lat);
    chk("lb3_rdata", rd, 32'h00000012);

    // 3: error cases
    wen_snap = wen_cycles;
    core_op(0, F3_H, 32'h103, 32'h0, rd, er, lat);
    chk("lh_mis_err", {31'b0, er}, 32'd1);
    chk("lh_mis_rdata", rd, 32'h0);
    chk("lh_mis_lat", 32'(lat), 32'd1);
    core_op(1, F3_W, 32'h102, 32'h55555555, rd, er, lat);
    chk("sw_mis_err", {31'b0, er}, 32'd1);
    core_op(1, F3_B, 32'h20000, 32'h77, rd, er, lat);
    chk("sb_oor_err", {31'b0, er}, 32'd1);
    chk("sb_oor_lat", 32'(lat), 32'd1);
    core_op(0, 3'b011, 32'h100, 32'h0, rd, er, lat);
    chk("f3_011_err", {31'b0, er}, 32'd1);
    core_op(1, F3_BU, 32'h100, 32'h0, rd, er, lat);
    chk("sbu_err", {31'b0, er}, 32'd1);
    ld_op(32'h202, 32'h99999999, lat);
    chk("ld_mis_lat", 32'(lat), 32'd1);
    chk("ld_mis_mem", mem[32'h80], 32'h0);
    chk("err_no_wen", 32'(wen_cycles - wen_snap), 32'd0);
    chk("err_mem_kept", mem[32'h40], 32'h1234AAEF);
    core_op(0, F3_BU, 32'h1FFFF, 32'h0, rd, er, lat);
    chk("lbu_top_err", {31'b0, er}, 32'd0);

    // 4: simultaneous loader and core, loader first
    core_valid = 1; core_wen = 1; core_funct3 = F3_W; core_addr = 32'h204; core_wdata = 32'hCAFEF00D;
    ld_valid = 1; ld_addr = 32'h200; ld_wdata = 32'h12345678;
    n = 0; ld_n = 0; core_n = 0;
    while (n < 30 && (ld_n == 0 || core_n == 0)) begin
      @(posedge clk); #1; n++;
      if (ld_n > 0 && n == ld_n + 1) ld_valid = 0;
      if (ld_done && ld_n == 0) ld_n = n;
      if (core_done && core_n == 0) core_n = n;
    end
    @(posedge clk); #1;
    core_valid = 0; ld_valid = 0;
    chk("arb_ld_cycle", 32'(ld_n), 32'd2);
    chk("arb_core_cycle", 32'(core_n), 32'd5);
    core_op(0, F3_W, 32'h200, 32'h0, rd, er, lat);
    chk("arb_ld_word", rd, 32'h12345678);
    core_op(0, F3_W, 32'h204, 32'h0, rd, er, lat);
    chk("arb_core_word", rd, 32'hCAFEF00D);

    // 5: reset during MERGE of a halfword store
    core_op(1, F3_W, 32'h300, 32'h11223344, rd, er, lat);
    core_valid = 1; core_wen = 1; core_funct3 = F3_H; core_addr = 32'h300; core_wdata = 32'hBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("merge_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_flags", {27'b0, mem_wen, core_done, core_err, ld_done, busy}, 32'h0);
    core_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_mem_word", mem[32'hC0], 32'h11223344);
    core_op(0, F3_W, 32'h300, 32'h0, rd, er, lat);
    chk("arst_lw", rd, 32'h11223344);

    // 6: mixed pseudo-random traffic against byte-array reference
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) < 2) begin
        a  = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
        if ($urandom_range(0, 7) == 0) a = a + 32'd1;
        wd = $urandom;
        ld_op(a, wd, lat);
        chk("rnd_ld_lat", 32'(lat), 32'd1);
        if (a[1:0] == 2'b00) begin
          rb[a[16:0]] = wd[7:0];       rb[a[16:0] + 17'd1] = wd[15:8];
          rb[a[16:0] + 17'd2] = wd[23:16]; rb[a[16:0] + 17'd3] = wd[31:24];
        end
      end else begin
        w  = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a  = 32'h1000 + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0) a = 32'h20000 + 32'($urandom_range(0, 7));
        wd = $urandom;
        xe = exp_err(w, f3, a);
        exp_rd = 32'h0;
        if (xe) exp_lat = 1;
        else if (!w) exp_lat = 2;
        else if (f3 == 3'd2) exp_lat = 1;
        else exp_lat = 3;
        if (!xe && !w) begin
          b0 = rb[a[16:0]]; b1 = rb[a[16:0] + 17'd1];
          b2 = rb[a[16:0] + 17'd2]; b3 = rb[a[16:0] + 17'd3];
          case (f3)
            3'd0: exp_rd = {{24{b0[7]}}, b0};
            3'd4: exp_rd = {24'h0, b0};
            3'd1: exp_rd = {{16{b1[7]}}, b1, b0};
            3'd5: exp_rd = {16'h0, b1, b0};
            default: exp_rd = {b3, b2, b1, b0};
          endcase
        end
        core_op(w, f3, a, wd, rd, er, lat);
        chk("rnd_err", {31'b0, er}, {31'b0, xe});
        chk("rnd_rdata", rd, exp_rd);
        chk("rnd_lat", 32'(lat), 32'(exp_lat));
        if (!xe && w) begin
          rb[a[16:0]] = wd[7:0];
          if (f3 != 3'd0) rb[a[16:0] + 17'd1] = wd[15:8];
          if (f3 == 3'd2) begin
            rb[a[16:0] + 17'd2] = wd[23:16]; rb[a[16:0] + 17'd3] = wd[31:24];
          end
        end
      end
    end
    for (int i = 0; i < 64; i++) begin
      a = 32'h1000 + 32'(i) * 4;
      chk("rnd_mem", mem[a[16:2]],
          {rb[a[16:0] + 17'd3], rb[a[16:0] + 17'd2], rb[a[16:0] + 17'd1], rb[a[16:0]]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
